// File: rtl/pgmon_pkg.sv
// pgmon_pkg: shared channel state encoding and stability-counter width helper
package pgmon_pkg;
    typedef enum logic [1:0] {IDLE, QUAL, GOOD, FAULT} pgmon_state_e;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/pgmon_chan.sv
// pgmon_chan: per-signal qualify/good/fault state machine with saturating stability counter
module pgmon_chan
    import pgmon_pkg::*;
#(
    parameter int STABLE_CNT = 16
) (
    input  logic iClk,
    input  logic iSRst,
    input  logic iEna,
    input  logic iMonEn,
    input  logic iSignal,
    input  logic iFaultClr,
    output logic oStable,
    output logic oFault,
    output logic oFaultNxt
);
    localparam int CW = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
    pgmon_state_e r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
    // next state: qualification only advances on timebase ticks, fault entry does not wait for one
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: if (iMonEn && iSignal) begin
                w_state_nxt = QUAL;
                w_cnt_nxt   = '0;
            end
            QUAL: if (!iMonEn || !iSignal) w_state_nxt = IDLE;
            else if (iEna) begin
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == CNT_MAX) w_state_nxt = GOOD;
            end
            GOOD: if (!iMonEn) w_state_nxt = IDLE;
            else if (!iSignal) w_state_nxt = FAULT;
            FAULT: if (iFaultClr) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    // state and counter registers
    always_ff @(posedge iClk) begin
        if (iSRst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
    assign oStable   = (r_state == GOOD);
    assign oFault    = (r_state == FAULT);
    assign oFaultNxt = (w_state_nxt == FAULT);
endmodule

// File: rtl/pwrgd_fault_monitor.sv
// pwrgd_fault_monitor: power-good stability/fault monitor; PGMON_FIRST_FAULT_EN adds first-fault index capture
module pwrgd_fault_monitor
    import pgmon_pkg::*;
#(
    parameter int NUMBER_OF_SIGNALS = 8,
    parameter int STABLE_CNT        = 16
) (
    input  logic                                 iClk,
    input  logic                                 iSRst,
    input  logic                                 iEna,
    input  logic [NUMBER_OF_SIGNALS-1:0]         iMonEn,
    input  logic [NUMBER_OF_SIGNALS-1:0]         iSignal,
    input  logic                                 iFaultClr,
    output logic [NUMBER_OF_SIGNALS-1:0]         oEdgeRise,
    output logic [NUMBER_OF_SIGNALS-1:0]         oEdgeFall,
    output logic [NUMBER_OF_SIGNALS-1:0]         oStable,
    output logic [NUMBER_OF_SIGNALS-1:0]         oFault,
    output logic                                 oFaultAny,
    output logic [$clog2(NUMBER_OF_SIGNALS)-1:0] oFirstFaultIdx,
    output logic                                 oFirstFaultVld
);
    localparam int N  = NUMBER_OF_SIGNALS;
    localparam int IW = $clog2(NUMBER_OF_SIGNALS);
    logic [N-1:0] w_fault_nxt, r_prev, r_rise, r_fall;
    logic         r_hist_vld, r_fault_any;
    for (genvar i = 0; i < N; i++) begin : g_chan
        pgmon_chan #(.STABLE_CNT(STABLE_CNT)) u_chan (
            .iClk     (iClk),
            .iSRst    (iSRst),
            .iEna     (iEna),
            .iMonEn   (iMonEn[i]),
            .iSignal  (iSignal[i]),
            .iFaultClr(iFaultClr),
            .oStable  (oStable[i]),
            .oFault   (oFault[i]),
            .oFaultNxt(w_fault_nxt[i])
        );
    end
    // edge detect; history must be refilled after reset before any edge is reported
    always_ff @(posedge iClk) begin
        if (iSRst) begin
            r_prev      <= '0;
            r_hist_vld  <= 1'b0;
            r_rise      <= '0;
            r_fall      <= '0;
            r_fault_any <= 1'b0;
        end else begin
            r_prev      <= iSignal;
            r_hist_vld  <= 1'b1;
            r_rise      <= r_hist_vld ? (iSignal & ~r_prev) : '0;
            r_fall      <= r_hist_vld ? (~iSignal & r_prev) : '0;
            r_fault_any <= |w_fault_nxt;
        end
    end
    assign oEdgeRise = r_rise;
    assign oEdgeFall = r_fall;
    assign oFaultAny = r_fault_any;
`ifdef PGMON_FIRST_FAULT_EN
    logic [N-1:0]  w_new;
    logic [IW-1:0] w_idx, r_idx;
    logic          r_vld;
    assign w_new = w_fault_nxt & ~oFault;
    // lowest-index channel newly entering fault this cycle
    always_comb begin
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) if (w_new[k]) w_idx = IW'(k);
    end
    // capture first fault; a clear coinciding with a new fault recaptures it
    always_ff @(posedge iClk) begin
        if (iSRst) begin
            r_idx <= '0;
            r_vld <= 1'b0;
        end else if (|w_new && (!r_vld || iFaultClr)) begin
            r_idx <= w_idx;
            r_vld <= 1'b1;
        end else if (iFaultClr) begin
            r_idx <= '0;
            r_vld <= 1'b0;
        end
    end
    assign oFirstFaultIdx = r_idx;
    assign oFirstFaultVld = r_vld;
`else
    assign oFirstFaultIdx = '0;
    assign oFirstFaultVld = 1'b0;
`endif
endmodule
